// File: rtl/branch_seq_pkg.sv
// Shared encodings for the SM83 control-flow sequencer: op codes, FSM states,
// address-select values and the level/pulse output bundles.
package branch_seq_pkg;

  typedef enum logic [1:0] {
    OP_JP   = 2'b00,
    OP_JR   = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RD_LO   = 4'd1,
    S_RD_HI   = 4'd2,
    S_RD_OFF  = 4'd3,
    S_COND    = 4'd4,
    S_PUSH_HI = 4'd5,
    S_PUSH_LO = 4'd6,
    S_POP_LO  = 4'd7,
    S_POP_HI  = 4'd8,
    S_EXEC    = 4'd9,
    S_FETCH   = 4'd10
  } state_e;

  localparam logic [1:0] ADDR_NONE = 2'b00;
  localparam logic [1:0] ADDR_PC   = 2'b01;
  localparam logic [1:0] ADDR_SP   = 2'b10;

  // Held for the whole M-cycle.
  typedef struct packed {
    logic [1:0] addr_sel;
    logic       mem_rd;
    logic       data_sel;
    logic       ir_fetch;
  } level_t;

  // Only meaningful on the last, unwaited step of an M-cycle.
  typedef struct packed {
    logic mem_wr;
    logic latch_z;
    logic latch_w;
    logic pc_inc;
    logic sp_inc;
    logic sp_dec;
    logic pc_load_wz;
    logic pc_add_z;
    logic done;
  } pulse_t;

  function automatic state_e first_state(input op_e op, input logic always_f);
    state_e s;
    case (op)
      OP_JP, OP_CALL: s = S_RD_LO;
      OP_JR:          s = S_RD_OFF;
      OP_RET:         s = always_f ? S_POP_LO : S_COND;
      default:        s = S_IDLE;
    endcase
    return s;
  endfunction

  // EXEC is the one M-cycle whose effect depends on the instruction.
  function automatic pulse_t exec_pulses(input op_e op);
    pulse_t p;
    p = '0;
    case (op)
      OP_JP, OP_RET: p.pc_load_wz = 1'b1;
      OP_JR:         p.pc_add_z   = 1'b1;
      OP_CALL:       p.sp_dec     = 1'b1;
      default:       p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/m_cycle_timer.sv
// T-step counter for one M-cycle: counts 0..STEPS-1 while running, holds
// under wait, and sits at 0 while idle.
module m_cycle_timer #(
  parameter int  STEPS = 4,
  localparam int SW    = $clog2(STEPS)
) (
  input  logic          i_Clk,
  input  logic          i_Reset_n,
  input  logic          i_Run,
  input  logic          i_Wait,
  output logic [SW-1:0] o_Step,
  output logic          o_Last
);

  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  logic [SW-1:0] step_q;
  logic [SW-1:0] step_d;

  always_comb begin
    step_d = step_q;
    if (!i_Run)                  step_d = '0;
    else if (i_Wait)             step_d = step_q;
    else if (step_q == LAST_STEP) step_d = '0;
    else                         step_d = step_q + 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) step_q <= '0;
    else            step_q <= step_d;
  end

  assign o_Step = step_q;
  assign o_Last = i_Run && (step_q == LAST_STEP);

endmodule

// File: rtl/branch_sequencer.sv
// Self-timed microcode sequencer for JP/JR/CALL/RET. Launched by i_Start from
// IDLE, it walks its M-cycles and signals completion with a one-cycle o_Done.
//
// Launch protocol: i_Start is sampled only while o_Busy is low; o_Done pulses
// on the final step of FETCH and o_Busy drops on the following clock, where a
// new i_Start is already accepted. There is no back-pressure on the launcher.
module branch_sequencer
  import branch_seq_pkg::*;
#(
  parameter int  STEPS  = 4,
  parameter int  COND_N = 4,
  localparam int SW     = $clog2(STEPS)
) (
  input  logic              i_Clk,
  input  logic              i_Reset_n,
  input  logic              i_Start,
  input  logic [1:0]        i_Op,
  input  logic [COND_N-1:0] i_Y,
  input  logic [COND_N-1:0] i_Conditions,
  input  logic              i_Always,
  input  logic              i_Wait,
  output logic              o_Busy,
  output logic [1:0]        o_Addr_Sel,
  output logic              o_Mem_Rd,
  output logic              o_Mem_Wr,
  output logic              o_Data_Sel,
  output logic              o_Latch_Z,
  output logic              o_Latch_W,
  output logic              o_PC_Inc,
  output logic              o_SP_Inc,
  output logic              o_SP_Dec,
  output logic              o_PC_Load_WZ,
  output logic              o_PC_Add_Z,
  output logic              o_IR_Fetch,
  output logic              o_Done,
  output logic [3:0]        o_Dbg_State,
  output logic [SW-1:0]     o_Dbg_Step,
  output logic [2:0]        o_Dbg_Mcycle
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic        taken_q, taken_d;
  logic        always_q, always_d;
  logic [2:0]  mcycle_q, mcycle_d;

  logic          run;
  logic          last_step;
  logic          advance;
  logic [SW-1:0] step;
  logic          accept;

  level_t level;
  pulse_t pulse_raw;
  pulse_t pulse;

  assign run     = (state_q != S_IDLE);
  assign accept  = (state_q == S_IDLE) && i_Start;
  assign advance = last_step && !i_Wait;

  m_cycle_timer #(
    .STEPS (STEPS)
  ) u_timer (
    .i_Clk     (i_Clk),
    .i_Reset_n (i_Reset_n),
    .i_Run     (run),
    .i_Wait    (i_Wait),
    .o_Step    (step),
    .o_Last    (last_step)
  );

  // State register plus the instruction context captured at launch.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_JP;
      taken_q  <= 1'b0;
      always_q <= 1'b0;
      mcycle_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      taken_q  <= taken_d;
      always_q <= always_d;
      mcycle_q <= mcycle_d;
    end
  end

  always_comb begin
    op_d     = op_q;
    taken_d  = taken_q;
    always_d = always_q;
    if (accept) begin
      op_d     = op_e'(i_Op);
      taken_d  = (|(i_Y & i_Conditions)) | i_Always;
      always_d = i_Always;
    end
  end

  always_comb begin
    mcycle_d = mcycle_q;
    if (state_d == S_IDLE) mcycle_d = '0;
    else if (advance)      mcycle_d = mcycle_q + 3'd1;
  end

  // Next-state logic: launch from IDLE, otherwise move only on an unwaited last step.
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (i_Start) state_d = first_state(op_e'(i_Op), i_Always);
    end else if (advance) begin
      case (state_q)
        S_RD_LO:             state_d = S_RD_HI;
        S_RD_HI, S_RD_OFF:   state_d = taken_q ? S_EXEC : S_FETCH;
        S_COND:              state_d = taken_q ? S_POP_LO : S_FETCH;
        S_POP_LO:            state_d = S_POP_HI;
        S_POP_HI:            state_d = S_EXEC;
        S_EXEC:              state_d = (op_q == OP_CALL) ? S_PUSH_HI : S_FETCH;
        S_PUSH_HI:           state_d = S_PUSH_LO;
        S_PUSH_LO:           state_d = S_FETCH;
        S_FETCH:             state_d = S_IDLE;
        default:             state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from registered state; pulses are gated by the timer.
  always_comb begin
    level     = '0;
    pulse_raw = '0;
    case (state_q)
      S_RD_LO: begin
        level.addr_sel    = ADDR_PC;
        level.mem_rd      = 1'b1;
        pulse_raw.latch_z = 1'b1;
        pulse_raw.pc_inc  = 1'b1;
      end
      S_RD_HI: begin
        level.addr_sel    = ADDR_PC;
        level.mem_rd      = 1'b1;
        pulse_raw.latch_w = 1'b1;
        pulse_raw.pc_inc  = 1'b1;
      end
      S_RD_OFF: begin
        level.addr_sel    = ADDR_PC;
        level.mem_rd      = 1'b1;
        pulse_raw.latch_z = 1'b1;
        pulse_raw.pc_inc  = 1'b1;
      end
      S_POP_LO: begin
        level.addr_sel    = ADDR_SP;
        level.mem_rd      = 1'b1;
        pulse_raw.latch_z = 1'b1;
        pulse_raw.sp_inc  = 1'b1;
      end
      S_POP_HI: begin
        level.addr_sel    = ADDR_SP;
        level.mem_rd      = 1'b1;
        pulse_raw.latch_w = 1'b1;
        pulse_raw.sp_inc  = 1'b1;
      end
      S_PUSH_HI: begin
        level.addr_sel    = ADDR_SP;
        level.data_sel    = 1'b1;
        pulse_raw.mem_wr  = 1'b1;
        pulse_raw.sp_dec  = 1'b1;
      end
      S_PUSH_LO: begin
        level.addr_sel       = ADDR_SP;
        pulse_raw.mem_wr     = 1'b1;
        pulse_raw.pc_load_wz = 1'b1;
      end
      S_EXEC: begin
        pulse_raw = exec_pulses(op_q);
      end
      S_FETCH: begin
        level.ir_fetch = 1'b1;
        pulse_raw.done = 1'b1;
      end
      default: begin
        level     = '0;
        pulse_raw = '0;
      end
    endcase
    pulse = advance ? pulse_raw : '0;
  end

  assign o_Busy       = run;
  assign o_Addr_Sel   = level.addr_sel;
  assign o_Mem_Rd     = level.mem_rd;
  assign o_Data_Sel   = level.data_sel;
  assign o_IR_Fetch   = level.ir_fetch;
  assign o_Mem_Wr     = pulse.mem_wr;
  assign o_Latch_Z    = pulse.latch_z;
  assign o_Latch_W    = pulse.latch_w;
  assign o_PC_Inc     = pulse.pc_inc;
  assign o_SP_Inc     = pulse.sp_inc;
  assign o_SP_Dec     = pulse.sp_dec;
  assign o_PC_Load_WZ = pulse.pc_load_wz;
  assign o_PC_Add_Z   = pulse.pc_add_z;
  assign o_Done       = pulse.done;

  assign o_Dbg_State  = state_q;
  assign o_Dbg_Step   = step;
  assign o_Dbg_Mcycle = mcycle_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed test-plan scenarios plus random
// instructions with random stalls, checked cycle by cycle against a table of M-cycles.
module tb_branch_sequencer;

  localparam int STEPS = 4;

  // Observed/expected vector layout.
  localparam logic [15:0] B_BUSY = 16'h8000;
  localparam logic [15:0] A_PC   = 16'h2000;
  localparam logic [15:0] A_SP   = 16'h4000;
  localparam logic [15:0] M_RD   = 16'h1000;
  localparam logic [15:0] M_WR   = 16'h0800;
  localparam logic [15:0] D_SEL  = 16'h0400;
  localparam logic [15:0] L_Z    = 16'h0200;
  localparam logic [15:0] L_W    = 16'h0100;
  localparam logic [15:0] PC_INC = 16'h0080;
  localparam logic [15:0] SP_INC = 16'h0040;
  localparam logic [15:0] SP_DEC = 16'h0020;
  localparam logic [15:0] PC_LD  = 16'h0010;
  localparam logic [15:0] PC_ADD = 16'h0008;
  localparam logic [15:0] IR_F   = 16'h0004;
  localparam logic [15:0] DONE   = 16'h0002;
  localparam logic [15:0] PULSES = M_WR | L_Z | L_W | PC_INC | SP_INC | SP_DEC | PC_LD | PC_ADD | DONE;

  logic       i_Clk = 1'b0;
  logic       i_Reset_n = 1'b0;
  logic       i_Start = 1'b0;
  logic [1:0] i_Op = 2'b00;
  logic [3:0] i_Y = 4'b0000;
  logic [3:0] i_Conditions = 4'b0000;
  logic       i_Always = 1'b0;
  logic       i_Wait = 1'b0;
  logic       o_Busy, o_Mem_Rd, o_Mem_Wr, o_Data_Sel, o_Latch_Z, o_Latch_W;
  logic       o_PC_Inc, o_SP_Inc, o_SP_Dec, o_PC_Load_WZ, o_PC_Add_Z, o_IR_Fetch, o_Done;
  logic [1:0] o_Addr_Sel;
  logic [3:0] o_Dbg_State;
  logic [1:0] o_Dbg_Step;
  logic [2:0] o_Dbg_Mcycle;
  logic [15:0] obs;

  int tests_run = 0;
  int tests_failed = 0;

  branch_sequencer #(.STEPS(STEPS), .COND_N(4)) dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .i_Start(i_Start), .i_Op(i_Op),
    .i_Y(i_Y), .i_Conditions(i_Conditions), .i_Always(i_Always), .i_Wait(i_Wait),
    .o_Busy(o_Busy), .o_Addr_Sel(o_Addr_Sel), .o_Mem_Rd(o_Mem_Rd), .o_Mem_Wr(o_Mem_Wr),
    .o_Data_Sel(o_Data_Sel), .o_Latch_Z(o_Latch_Z), .o_Latch_W(o_Latch_W),
    .o_PC_Inc(o_PC_Inc), .o_SP_Inc(o_SP_Inc), .o_SP_Dec(o_SP_Dec),
    .o_PC_Load_WZ(o_PC_Load_WZ), .o_PC_Add_Z(o_PC_Add_Z), .o_IR_Fetch(o_IR_Fetch),
    .o_Done(o_Done), .o_Dbg_State(o_Dbg_State), .o_Dbg_Step(o_Dbg_Step),
    .o_Dbg_Mcycle(o_Dbg_Mcycle)
  );

  assign obs = {o_Busy, o_Addr_Sel, o_Mem_Rd, o_Mem_Wr, o_Data_Sel, o_Latch_Z, o_Latch_W,
                o_PC_Inc, o_SP_Inc, o_SP_Dec, o_PC_Load_WZ, o_PC_Add_Z, o_IR_Fetch,
                o_Done, 1'b0};

  // Clock.
  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    tests_run++;
    assert (got === want) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Reference model: the M-cycle list of one instruction, each entry being the
  // output vector seen on its last unwaited step.
  task automatic build_model(input logic [1:0] op, input bit taken, input bit alw,
                             output logic [15:0] exp_q[$]);
    logic [15:0] rd_lo, rd_hi, fetch;
    rd_lo = B_BUSY | A_PC | M_RD | L_Z | PC_INC;
    rd_hi = B_BUSY | A_PC | M_RD | L_W | PC_INC;
    fetch = B_BUSY | IR_F | DONE;
    exp_q = {};
    case (op)
      2'b00: begin
        exp_q.push_back(rd_lo);
        exp_q.push_back(rd_hi);
        if (taken) exp_q.push_back(B_BUSY | PC_LD);
      end
      2'b01: begin
        exp_q.push_back(rd_lo);
        if (taken) exp_q.push_back(B_BUSY | PC_ADD);
      end
      2'b10: begin
        exp_q.push_back(rd_lo);
        exp_q.push_back(rd_hi);
        if (taken) begin
          exp_q.push_back(B_BUSY | SP_DEC);
          exp_q.push_back(B_BUSY | A_SP | M_WR | D_SEL | SP_DEC);
          exp_q.push_back(B_BUSY | A_SP | M_WR | PC_LD);
        end
      end
      default: begin
        if (!alw) exp_q.push_back(B_BUSY);
        if (taken) begin
          exp_q.push_back(B_BUSY | A_SP | M_RD | L_Z | SP_INC);
          exp_q.push_back(B_BUSY | A_SP | M_RD | L_W | SP_INC);
          exp_q.push_back(B_BUSY | PC_LD);
        end
      end
    endcase
    exp_q.push_back(fetch);
  endtask

  // Driver + scoreboard for one instruction. wmode: 0 no wait, 1 random wait
  // and stray starts, 2 wait on cycles 4..6. abort_at>0 pulls reset on that cycle.
  task automatic run_seq(input string name, input logic [1:0] op, input logic [3:0] y,
                         input logic [3:0] cond, input logic alw, input int wmode,
                         input int abort_at, output int done_cyc);
    logic [15:0] exp_q[$];
    logic [15:0] exp;
    bit taken;
    bit w;
    int idx, step, n;
    taken = ((y & cond) != 4'b0000) || alw;
    build_model(op, taken, alw, exp_q);
    done_cyc = -1;

    @(negedge i_Clk);
    i_Start = 1'b1; i_Op = op; i_Y = y; i_Conditions = cond; i_Always = alw; i_Wait = 1'b0;
    #1 chk($sformatf("%s idle", name), obs, 16'h0000);

    idx = 0; step = 0; n = 0;
    while (idx < exp_q.size() && n < 400) begin
      @(negedge i_Clk);
      n++;
      i_Start = (wmode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      i_Op = 2'($urandom); i_Y = 4'($urandom); i_Conditions = 4'($urandom);
      i_Always = 1'($urandom);
      w = (wmode == 1) ? ($urandom_range(0, 3) == 0) : (wmode == 2) ? (n >= 4 && n <= 6) : 1'b0;
      i_Wait = w;
      #1;
      exp = exp_q[idx];
      if (w || step != STEPS - 1) exp = exp & ~PULSES;
      chk($sformatf("%s c%0d", name, n), obs, exp);
      if (o_Done) done_cyc = n;
      if (n == abort_at) begin
        i_Reset_n = 1'b0;
        @(negedge i_Clk);
        i_Start = 1'b0; i_Wait = 1'b0;
        #1;
        chk($sformatf("%s rst_out", name), obs, 16'h0000);
        chk($sformatf("%s rst_mcyc", name), {13'b0, o_Dbg_Mcycle}, 16'h0000);
        i_Reset_n = 1'b1;
        return;
      end
      if (!w) begin
        if (step == STEPS - 1) begin
          step = 0;
          idx++;
        end else begin
          step++;
        end
      end
    end
    chk($sformatf("%s timeout", name), 16'(idx), 16'(exp_q.size()));
    i_Start = 1'b0;
  endtask

  initial begin
    int lat;
    logic [1:0] rop;
    logic [3:0] ry;

    // Reset.
    i_Reset_n = 1'b0;
    repeat (3) @(negedge i_Clk);
    #1;
    chk("reset_out", obs, 16'h0000);
    chk("reset_mcyc", {13'b0, o_Dbg_Mcycle}, 16'h0000);
    i_Reset_n = 1'b1;

    run_seq("jp_taken", 2'b00, 4'b0001, 4'b0000, 1'b1, 0, 0, lat);
    chk("jp_taken_lat", 16'(lat), 16'd16);

    run_seq("jp_nz_nt", 2'b00, 4'b0001, 4'b0000, 1'b0, 0, 0, lat);
    chk("jp_nz_nt_lat", 16'(lat), 16'd12);

    run_seq("jr_taken", 2'b01, 4'b0010, 4'b0010, 1'b0, 0, 0, lat);
    chk("jr_taken_lat", 16'(lat), 16'd12);

    run_seq("call_taken", 2'b10, 4'b0000, 4'b0000, 1'b1, 0, 0, lat);
    chk("call_taken_lat", 16'(lat), 16'd24);

    run_seq("call_nt", 2'b10, 4'b0100, 4'b1011, 1'b0, 0, 0, lat);
    chk("call_nt_lat", 16'(lat), 16'd12);

    // Conditional RET not taken, then unconditional RET with no bubble.
    run_seq("ret_c_nt", 2'b11, 4'b1000, 4'b0111, 1'b0, 0, 0, lat);
    chk("ret_c_nt_lat", 16'(lat), 16'd8);
    run_seq("ret_uncond", 2'b11, 4'b0000, 4'b0000, 1'b1, 0, 0, lat);
    chk("ret_uncond_lat", 16'(lat), 16'd16);

    run_seq("ret_z_taken", 2'b11, 4'b0010, 4'b0010, 1'b0, 0, 0, lat);
    chk("ret_z_taken_lat", 16'(lat), 16'd20);

    run_seq("jp_stall", 2'b00, 4'b1000, 4'b1000, 1'b0, 2, 0, lat);
    chk("jp_stall_lat", 16'(lat), 16'd19);

    // Reset during PUSH_HI (cycles 13..16), then a clean instruction.
    run_seq("call_abort", 2'b10, 4'b0000, 4'b0000, 1'b1, 0, 14, lat);
    run_seq("jp_after_rst", 2'b00, 4'b0100, 4'b0100, 1'b0, 0, 0, lat);
    chk("jp_after_rst_lat", 16'(lat), 16'd16);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom);
      ry  = 4'b0001 << $urandom_range(0, 3);
      run_seq($sformatf("rnd%0d", i), rop, ry, 4'($urandom), 1'($urandom_range(0, 3) == 0),
              1, 0, lat);
    end

    @(negedge i_Clk);
    i_Start = 1'b0;
    #1 chk("final_idle", obs, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
